// File: rtl/cdb_arbiter_if.sv
//------------------------------------------------------------------------------
// cdb_arbiter_if : FU result handshake and common data bus broadcast signals
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if #(
  parameter int NUM_FU     = 5,
  parameter int DATA_WIDTH = 6,
  parameter int ROB_DEPTH  = 16,
  parameter int XLEN       = 32
);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int ID_W  = $clog2(NUM_FU);

  logic                                jump_commit;
  logic [NUM_FU-1:0]                   fu_valid;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0]   fu_pd;
  logic [NUM_FU-1:0]                   fu_regf_we;
  logic [NUM_FU-1:0][ROB_W-1:0]        fu_rob_idx;
  logic [NUM_FU-1:0][XLEN-1:0]         fu_data;
  logic [NUM_FU-1:0]                   fu_ready;
  logic                                cdb_valid;
  logic [DATA_WIDTH-1:0]               cdb_pd;
  logic                                cdb_regf_we;
  logic [ROB_W-1:0]                    cdb_rob_idx;
  logic [XLEN-1:0]                     cdb_data;
  logic [ID_W-1:0]                     cdb_grant_id;
  logic                                wakeup;
  logic [DATA_WIDTH-1:0]               pd_broadcast;
  logic [31:0]                         conflict_count;

  modport master (
    output jump_commit, fu_valid, fu_pd, fu_regf_we, fu_rob_idx, fu_data,
    input  fu_ready, cdb_valid, cdb_pd, cdb_regf_we, cdb_rob_idx, cdb_data,
           cdb_grant_id, wakeup, pd_broadcast, conflict_count
  );

  modport slave (
    input  jump_commit, fu_valid, fu_pd, fu_regf_we, fu_rob_idx, fu_data,
    output fu_ready, cdb_valid, cdb_pd, cdb_regf_we, cdb_rob_idx, cdb_data,
           cdb_grant_id, wakeup, pd_broadcast, conflict_count
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// cdb_arbiter : one-entry result buffers per FU, round-robin grant onto the CDB
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
  parameter int NUM_FU     = 5,
  parameter int DATA_WIDTH = 6,
  parameter int ROB_DEPTH  = 16,
  parameter int XLEN       = 32
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int ID_W  = $clog2(NUM_FU);
  localparam logic [ID_W:0] NUM_FU_W = (ID_W+1)'(NUM_FU);

  logic [NUM_FU-1:0]                 hold_valid_q, hold_valid_d;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0] hold_pd_q, hold_pd_d;
  logic [NUM_FU-1:0]                 hold_we_q, hold_we_d;
  logic [NUM_FU-1:0][ROB_W-1:0]      hold_rob_q, hold_rob_d;
  logic [NUM_FU-1:0][XLEN-1:0]       hold_data_q, hold_data_d;
  logic [ID_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [31:0]                       conflict_count_q, conflict_count_d;

  logic              any_valid;
  logic              grant;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     hv_count;
  logic [NUM_FU-1:0] ready;

  // Search starts at rr_ptr and wraps; only registered entries compete.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= NUM_FU_W) cand = cand - NUM_FU_W;
      if (!any_valid && hold_valid_q[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[ID_W-1:0];
      end
    end
  end

  assign grant = any_valid & ~bus.jump_commit;

  always_comb begin
    hv_count = '0;
    for (int i = 0; i < NUM_FU; i++) hv_count = hv_count + (ID_W+1)'(hold_valid_q[i]);
  end

  always_comb begin
    hold_valid_d     = hold_valid_q;
    hold_pd_d        = hold_pd_q;
    hold_we_d        = hold_we_q;
    hold_rob_d       = hold_rob_q;
    hold_data_d      = hold_data_q;
    rr_ptr_d         = rr_ptr_q;
    conflict_count_d = conflict_count_q;
    ready            = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = rst & ~bus.jump_commit &
                 (~hold_valid_q[i] | (grant && (winner == ID_W'(i))));
    end
    if (bus.jump_commit) begin
      hold_valid_d = '0;
    end else begin
      if (grant) begin
        hold_valid_d[winner] = 1'b0;
        rr_ptr_d = (winner == ID_W'(NUM_FU - 1)) ? '0 : winner + ID_W'(1);
      end
      // A same-cycle accept overrides the grant clear, so the entry refills without a bubble.
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && ready[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_pd_d[i]    = bus.fu_pd[i];
          hold_we_d[i]    = bus.fu_regf_we[i];
          hold_rob_d[i]   = bus.fu_rob_idx[i];
          hold_data_d[i]  = bus.fu_data[i];
        end
      end
      if ((hv_count > (ID_W+1)'(1)) && (conflict_count_q != 32'hFFFF_FFFF))
        conflict_count_d = conflict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q     <= '0;
      hold_pd_q        <= '0;
      hold_we_q        <= '0;
      hold_rob_q       <= '0;
      hold_data_q      <= '0;
      rr_ptr_q         <= '0;
      conflict_count_q <= '0;
    end else begin
      hold_valid_q     <= hold_valid_d;
      hold_pd_q        <= hold_pd_d;
      hold_we_q        <= hold_we_d;
      hold_rob_q       <= hold_rob_d;
      hold_data_q      <= hold_data_d;
      rr_ptr_q         <= rr_ptr_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign bus.fu_ready       = ready;
  assign bus.cdb_valid      = grant;
  assign bus.cdb_pd         = grant ? hold_pd_q[winner]   : '0;
  assign bus.cdb_regf_we    = grant ? hold_we_q[winner]   : 1'b0;
  assign bus.cdb_rob_idx    = grant ? hold_rob_q[winner]  : '0;
  assign bus.cdb_data       = grant ? hold_data_q[winner] : '0;
  assign bus.cdb_grant_id   = grant ? winner : '0;
  assign bus.wakeup         = grant & hold_we_q[winner] & (hold_pd_q[winner] != '0);
  assign bus.pd_broadcast   = bus.cdb_pd;
  assign bus.conflict_count = conflict_count_q;
endmodule

`default_nettype wire
